// File: rtl/prbs_cfg_loader_if.sv
// Byte-stream configuration handshake between the host/sequencer and prbs_cfg_loader.
// A byte transfers on any rising edge where byte_valid && byte_ready.
interface prbs_cfg_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/prbs_cfg_loader.sv
// Assembles an MSB-first byte stream into the PRBS seed word and repetition count,
// fires a one-cycle start pulse, then watches pattern_correct under a timeout watchdog.
module prbs_cfg_loader #(
    parameter int data_width       = 32,
    parameter int Repetitive_width = 8,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int CNT_W            = 11
) (
    input  logic                        CLK,
    input  logic                        RST,
    prbs_cfg_loader_if.slave            byte_if,
    output logic [data_width-1:0]       prbs_in,
    output logic [Repetitive_width-1:0] prbs_n,
    output logic                        prbs_valid,
    input  logic                        pattern_correct,
    output logic                        busy,
    output logic                        test_pass,
    output logic                        test_fail,
    output logic                        cfg_err
);

    localparam int NBYTES = data_width / 8 + Repetitive_width / 8;
    localparam int BW     = $clog2(NBYTES + 1);
    localparam int TW     = data_width + Repetitive_width;

    typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, ERR} state_t;

    state_t           state, next_state;
    logic [BW-1:0]    byte_cnt, byte_cnt_nxt;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [TW-1:0]    cfg_q, cfg_nxt, cfg_shift;
    logic             pass_nxt, fail_nxt;
    logic             xfer;

    assign xfer      = byte_if.byte_valid && byte_if.byte_ready;
    // Shifting in MSB-first leaves the first byte at the top of IN and the last in N.
    assign cfg_shift = {cfg_q[TW-9:0], byte_if.byte_in};
    assign prbs_in   = cfg_q[TW-1 -: data_width];
    assign prbs_n    = cfg_q[Repetitive_width-1:0];
    assign busy      = (state != IDLE);

    always_comb begin
        next_state   = state;
        byte_cnt_nxt = byte_cnt;
        tmo_cnt_nxt  = tmo_cnt;
        cfg_nxt      = cfg_q;
        pass_nxt     = 1'b0;
        fail_nxt     = 1'b0;
        if (xfer) cfg_nxt = cfg_shift;
        unique case (state)
            IDLE: if (xfer) begin
                byte_cnt_nxt = BW'(1);
                next_state   = LOAD;
            end
            LOAD: if (xfer) begin
                if (byte_cnt == BW'(NBYTES - 1)) begin
                    byte_cnt_nxt = '0;
                    next_state   = (cfg_shift[Repetitive_width-1:0] == '0) ? ERR : FIRE;
                end else begin
                    byte_cnt_nxt = byte_cnt + 1'b1;
                end
            end
            FIRE: begin
                tmo_cnt_nxt = '0;
                next_state  = WAIT;
            end
            WAIT: begin
                tmo_cnt_nxt = tmo_cnt + 1'b1;
                if (pattern_correct) begin
                    pass_nxt   = 1'b1;
                    next_state = IDLE;
                end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fail_nxt   = 1'b1;
                    next_state = IDLE;
                end
            end
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // All handshake/status outputs are registered from next_state so they track the
    // state they belong to while still reading as zero in the cycle after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state              <= IDLE;
            byte_cnt           <= '0;
            tmo_cnt            <= '0;
            cfg_q              <= '0;
            prbs_valid         <= 1'b0;
            byte_if.byte_ready <= 1'b0;
            test_pass          <= 1'b0;
            test_fail          <= 1'b0;
            cfg_err            <= 1'b0;
        end else begin
            state              <= next_state;
            byte_cnt           <= byte_cnt_nxt;
            tmo_cnt            <= tmo_cnt_nxt;
            cfg_q              <= cfg_nxt;
            prbs_valid         <= (next_state == FIRE);
            byte_if.byte_ready <= (next_state == IDLE) || (next_state == LOAD);
            test_pass          <= pass_nxt;
            test_fail          <= fail_nxt;
            cfg_err            <= (next_state == ERR);
        end
    end

endmodule
